// File: rtl/bus_pkg.sv
// Shared datapath bus codes: source/destination select values and legality limits
// used by the transfer controller and the bus multiplexer.
package bus_pkg;

  localparam int SEL_W   = 5;
  localparam int NUM_DST = 24;

  // Bus sources driven onto the shared datapath bus
  localparam int SRC_R0      = 0;
  localparam int SRC_R15     = 15;
  localparam int SRC_HI      = 16;
  localparam int SRC_LO      = 17;
  localparam int SRC_ZHI     = 18;
  localparam int SRC_ZLO     = 19;
  localparam int SRC_PC      = 20;
  localparam int SRC_MDR     = 21;
  localparam int SRC_INPORT  = 22;
  localparam int SRC_SIGNEXT = 23;

  // Registers that can load from the bus
  localparam int DST_R0      = 0;
  localparam int DST_R15     = 15;
  localparam int DST_HI      = 16;
  localparam int DST_LO      = 17;
  localparam int DST_Y       = 18;
  localparam int DST_PC      = 19;
  localparam int DST_MDR     = 20;
  localparam int DST_MAR     = 21;
  localparam int DST_IR      = 22;
  localparam int DST_OUTPORT = 23;

  localparam int SRC_LAST = SRC_SIGNEXT;
  localparam int DST_LAST = DST_OUTPORT;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO: DEPTH entries of W bits, registered occupancy count.
// Pushes while full and pops while empty are ignored.
module cmd_fifo
  import bus_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 10
) (
  input  logic                     clk,
  input  logic                     clr_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && (count < CW'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign dout    = mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap by natural overflow
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/bus_xfer_ctrl.sv
// Register-transfer issue controller: queues (src, dst) commands and issues one per
// cycle as a registered bus select plus a one-hot destination load pulse.
module bus_xfer_ctrl #(
  parameter int DEPTH   = 4,
  parameter int SEL_W   = bus_pkg::SEL_W,
  parameter int NUM_DST = bus_pkg::NUM_DST
) (
  input  logic                   clk,
  input  logic                   clr_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [SEL_W-1:0]       cmd_src,
  input  logic [SEL_W-1:0]       cmd_dst,
  input  logic                   stall,
  input  logic                   err_clr,
  output logic [SEL_W-1:0]       bus_sel,
  output logic [NUM_DST-1:0]     dst_ld,
  output logic                   xfer_active,
  output logic                   err_illegal,
  output logic [$clog2(DEPTH):0] fifo_count
);

  import bus_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [SEL_W-1:0] SRC_MAX = SEL_W'(SRC_LAST);
  localparam logic [SEL_W-1:0] DST_MAX = SEL_W'(DST_LAST);

  logic [2*SEL_W-1:0] head;
  logic [SEL_W-1:0]   head_src;
  logic [SEL_W-1:0]   head_dst;
  logic               push;
  logic               issue;
  logic               legal;

  // Handshake: a command transfers on any edge where cmd_valid && cmd_ready are both
  // high; cmd_ready comes from the registered count only, so it never depends on cmd_valid.
  assign cmd_ready = fifo_count < CW'(DEPTH);
  assign push      = cmd_valid && cmd_ready;

  cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (2 * SEL_W)
  ) u_fifo (
    .clk   (clk),
    .clr_n (clr_n),
    .push  (push),
    .pop   (issue),
    .din   ({cmd_src, cmd_dst}),
    .dout  (head),
    .count (fifo_count)
  );

  assign head_src = head[2*SEL_W-1:SEL_W];
  assign head_dst = head[SEL_W-1:0];
  assign issue    = (fifo_count != '0) && !stall;
  assign legal    = (head_src <= SRC_MAX) && (head_dst <= DST_MAX);

  // bus_sel only moves on a legal issue so the bus stays stable between transfers
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      bus_sel     <= '0;
      dst_ld      <= '0;
      err_illegal <= 1'b0;
    end else begin
      dst_ld <= '0;
      if (issue && legal) begin
        bus_sel <= head_src;
        dst_ld  <= NUM_DST'(1) << head_dst;
      end
      if (issue && !legal)
        err_illegal <= 1'b1;
      else if (err_clr)
        err_illegal <= 1'b0;
    end
  end

  assign xfer_active = |dst_ld;

endmodule
